// File: rtl/fpu_cmd_issuer.sv
// fpu_cmd_issuer
// Host-side initiator for the single-precision FPU command port. Host
// requests are buffered in a DEPTH-entry FIFO. One command at a time is
// issued to the FPU. The FPU's valid/rdy handshake is followed with a
// timeout. Result, compare flags, tag and error code are returned on a
// valid/ready response port in request order.
//
// Ports
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   req_valid_i / req_ready_o          host request handshake
//   req_cmd_i, req_a_i, req_b_i,       opcode, operands, tag
//   req_tag_i
//   resp_valid_o / resp_ready_i        response handshake
//   resp_data_o, resp_flags_o,         result, {gt,lt,eq}, tag, error code
//   resp_tag_o, resp_err_o
//   fpu_cmd_o, fpu_din1_o, fpu_din2_o  command/operands to the FPU, held from
//                                      issue until the next load
//   fpu_dval_o                         one-cycle issue strobe
//   fpu_kill_o                         one-cycle abort pulse on timeout
//   fpu_result_i, fpu_valid_i,         FPU return path
//   fpu_rdy_i, fpu_gt_i, fpu_lt_i,
//   fpu_eq_i
//   busy_o, fifo_count_o               activity and FIFO occupancy
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a queued request and an idle FPU
// ISSUE     | fpu_dval strobe, timeout timer loaded
// WAIT_VAL  | waiting for fpu_valid, timer counting down to abort
// WAIT_RDY  | result captured, waiting for the FPU to report ready
// RESP      | response held on the port until the host accepts it

module fpu_cmd_issuer #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_i,

   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [3:0]               req_cmd_i,
   input  logic [31:0]              req_a_i,
   input  logic [31:0]              req_b_i,
   input  logic [TAG_W-1:0]         req_tag_i,

   output logic                     resp_valid_o,
   input  logic                     resp_ready_i,
   output logic [31:0]              resp_data_o,
   output logic [2:0]               resp_flags_o,
   output logic [TAG_W-1:0]         resp_tag_o,
   output logic [1:0]               resp_err_o,

   output logic [3:0]               fpu_cmd_o,
   output logic [31:0]              fpu_din1_o,
   output logic [31:0]              fpu_din2_o,
   output logic                     fpu_dval_o,
   input  logic [31:0]              fpu_result_i,
   input  logic                     fpu_valid_i,
   input  logic                     fpu_rdy_i,
   input  logic                     fpu_gt_i,
   input  logic                     fpu_lt_i,
   input  logic                     fpu_eq_i,
   output logic                     fpu_kill_o,

   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_WAIT_VAL = 3'd2;
   localparam logic [2:0] S_WAIT_RDY = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_CMP = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_CMD = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;

   // ---------------------------------------------------------------
   // Request FIFO
   // ---------------------------------------------------------------
   logic [3:0]        fifo_cmd_q [DEPTH];
   logic [31:0]       fifo_a_q   [DEPTH];
   logic [31:0]       fifo_b_q   [DEPTH];
   logic [TAG_W-1:0]  fifo_tag_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              push;
   logic              pop;
   logic              fifo_empty;

   logic [3:0]        head_cmd;
   logic [31:0]       head_a;
   logic [31:0]       head_b;
   logic [TAG_W-1:0]  head_tag;
   logic              head_ok;

   // ---------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------
   logic [2:0]        state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              fpu_idle_q, fpu_idle_d;
   logic              kill;

   logic [3:0]        fpu_cmd_q, fpu_cmd_d;
   logic [31:0]       fpu_din1_q, fpu_din1_d;
   logic [31:0]       fpu_din2_q, fpu_din2_d;

   logic [31:0]       rsp_data_q, rsp_data_d;
   logic [2:0]        rsp_flags_q, rsp_flags_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [1:0]        rsp_err_q, rsp_err_d;

   assign fifo_empty  = (count_q == '0);
   assign req_ready_o = (count_q < CNT_W'(DEPTH));
   assign push        = req_valid_i && req_ready_o;
   // Only one command in flight: pop only when idle and the FPU is free.
   assign pop         = (state_q == S_IDLE) && !fifo_empty && fpu_idle_q;

   assign head_cmd = fifo_cmd_q[rd_ptr_q];
   assign head_a   = fifo_a_q[rd_ptr_q];
   assign head_b   = fifo_b_q[rd_ptr_q];
   assign head_tag = fifo_tag_q[rd_ptr_q];

   always_comb begin
      case (head_cmd)
         OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_DIV: head_ok = 1'b1;
         default:                                head_ok = 1'b0;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Payload storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_cmd_q[wr_ptr_q] <= req_cmd_i;
         fifo_a_q[wr_ptr_q]   <= req_a_i;
         fifo_b_q[wr_ptr_q]   <= req_b_i;
         fifo_tag_q[wr_ptr_q] <= req_tag_i;
      end
   end

   // ---------------------------------------------------------------
   // Command FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      kill        = 1'b0;
      fpu_cmd_d   = fpu_cmd_q;
      fpu_din1_d  = fpu_din1_q;
      fpu_din2_d  = fpu_din2_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               rsp_tag_d = head_tag;
               if (!head_ok) begin
                  // Unsupported opcodes never reach the FPU.
                  rsp_data_d  = '0;
                  rsp_flags_d = '0;
                  rsp_err_d   = ERR_CMD;
                  state_d     = S_RESP;
               end else begin
                  fpu_cmd_d  = head_cmd;
                  fpu_din1_d = head_a;
                  fpu_din2_d = head_b;
                  state_d    = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            // Down-counter: reaching zero is the TIMEOUT-th cycle after
            // entering WAIT_VAL.
            tmr_d   = TMR_W'(TIMEOUT);
            state_d = S_WAIT_VAL;
         end

         S_WAIT_VAL: begin
            if (fpu_valid_i) begin
               if (fpu_cmd_q == OP_CMP) begin
                  rsp_data_d  = '0;
                  rsp_flags_d = {fpu_gt_i, fpu_lt_i, fpu_eq_i};
               end else begin
                  rsp_data_d  = fpu_result_i;
                  rsp_flags_d = '0;
               end
               rsp_err_d = ERR_OK;
               state_d   = S_WAIT_RDY;
            end else if (tmr_q == '0) begin
               kill        = 1'b1;
               rsp_data_d  = '0;
               rsp_flags_d = '0;
               rsp_err_d   = ERR_TMO;
               state_d     = S_RESP;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         S_WAIT_RDY: begin
            if (fpu_rdy_i) begin
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            if (resp_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The issue strobe wins over a stale rdy seen in the same cycle; a kill
   // leaves the FPU reset, so it counts as idle afterwards.
   always_comb begin
      fpu_idle_d = fpu_idle_q;
      if (state_q == S_ISSUE) begin
         fpu_idle_d = 1'b0;
      end else if (fpu_rdy_i || kill) begin
         fpu_idle_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         fpu_idle_q  <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fpu_cmd_q   <= '0;
         fpu_din1_q  <= '0;
         fpu_din2_q  <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         rsp_tag_q   <= '0;
         rsp_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         fpu_idle_q  <= fpu_idle_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fpu_cmd_q   <= fpu_cmd_d;
         fpu_din1_q  <= fpu_din1_d;
         fpu_din2_q  <= fpu_din2_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign fpu_cmd_o    = fpu_cmd_q;
   assign fpu_din1_o   = fpu_din1_q;
   assign fpu_din2_o   = fpu_din2_q;
   assign fpu_dval_o   = (state_q == S_ISSUE);
   assign fpu_kill_o   = kill;

   assign resp_valid_o = (state_q == S_RESP);
   assign resp_data_o  = rsp_data_q;
   assign resp_flags_o = rsp_flags_q;
   assign resp_tag_o   = rsp_tag_q;
   assign resp_err_o   = rsp_err_q;

   assign busy_o       = (state_q != S_IDLE) || !fifo_empty;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
module tb_fpu_cmd_issuer;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 255;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   req_valid_i;
   logic                   req_ready_o;
   logic [3:0]             req_cmd_i;
   logic [31:0]            req_a_i;
   logic [31:0]            req_b_i;
   logic [TAG_W-1:0]       req_tag_i;
   logic                   resp_valid_o;
   logic                   resp_ready_i;
   logic [31:0]            resp_data_o;
   logic [2:0]             resp_flags_o;
   logic [TAG_W-1:0]       resp_tag_o;
   logic [1:0]             resp_err_o;
   logic [3:0]             fpu_cmd_o;
   logic [31:0]            fpu_din1_o;
   logic [31:0]            fpu_din2_o;
   logic                   fpu_dval_o;
   logic [31:0]            fpu_result_i = '0;
   logic                   fpu_valid_i  = 1'b0;
   logic                   fpu_rdy_i    = 1'b1;
   logic                   fpu_gt_i     = 1'b0;
   logic                   fpu_lt_i     = 1'b0;
   logic                   fpu_eq_i     = 1'b0;
   logic                   fpu_kill_o;
   logic                   busy_o;
   logic [$clog2(DEPTH):0] fifo_count_o;

   fpu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_cmd_i(req_cmd_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
      .req_tag_i(req_tag_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_data_o(resp_data_o), .resp_flags_o(resp_flags_o),
      .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o),
      .fpu_cmd_o(fpu_cmd_o), .fpu_din1_o(fpu_din1_o), .fpu_din2_o(fpu_din2_o),
      .fpu_dval_o(fpu_dval_o), .fpu_result_i(fpu_result_i),
      .fpu_valid_i(fpu_valid_i), .fpu_rdy_i(fpu_rdy_i),
      .fpu_gt_i(fpu_gt_i), .fpu_lt_i(fpu_lt_i), .fpu_eq_i(fpu_eq_i),
      .fpu_kill_o(fpu_kill_o),
      .busy_o(busy_o), .fifo_count_o(fifo_count_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
      end
   endtask

   // FPU result function (what the FPU model produces); 1.0+2.0 is exact.
   function automatic logic [31:0] fpu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      if (c == 4'h1 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return (a ^ {b[15:0], b[31:16]}) + {28'h0, c} + 32'h1;
   endfunction

   // ---------------- FPU behavioural model ----------------
   int   lat_as  = 17;
   int   lat_mul = 5;
   int   lat_div = 9;
   bit   hang    = 1'b0;
   bit   m_busy  = 1'b0;
   int   m_cnt   = 0;
   logic [3:0]  m_cmd;
   logic [31:0] m_a, m_b;

   always @(negedge clk_i) begin
      if (rst_i || fpu_kill_o) begin
         m_busy = 1'b0; m_cnt = 0;
         fpu_valid_i = 1'b0; fpu_rdy_i = 1'b1; fpu_result_i = '0;
         fpu_gt_i = 1'b0; fpu_lt_i = 1'b0; fpu_eq_i = 1'b0;
      end else if (fpu_valid_i) begin
         fpu_valid_i = 1'b0; fpu_rdy_i = 1'b1; m_busy = 1'b0;
      end else if (m_busy) begin
         if (m_cnt > 1) m_cnt--;
         else if (!hang) begin
            fpu_valid_i  = 1'b1;
            fpu_result_i = fpu_fn(m_cmd, m_a, m_b);
            fpu_gt_i = (m_a > m_b); fpu_lt_i = (m_a < m_b); fpu_eq_i = (m_a == m_b);
         end
      end else if (fpu_dval_o) begin
         m_busy = 1'b1; fpu_rdy_i = 1'b0;
         m_cmd = fpu_cmd_o; m_a = fpu_din1_o; m_b = fpu_din2_o;
         m_cnt = (m_cmd == 4'h3) ? lat_mul : (m_cmd == 4'h5) ? lat_div : lat_as;
      end
   end

   // ---------------- Monitors (record only) ----------------
   int cyc = 0, dval_cnt = 0, kill_cnt = 0, hs_cnt = 0;
   int dval_cyc = -1, kill_cyc = -1, fval_cyc = -1, hs_cyc = -1;
   int min_gap = 100000, max_cnt = 0, dval_double = 0, stab_bad = 0;
   logic prev_dval = 1'b0, prev_stall = 1'b0;
   logic [31:0] p_data; logic [2:0] p_flags; logic [TAG_W-1:0] p_tag; logic [1:0] p_err;

   always @(posedge clk_i) begin
      if (fpu_dval_o) begin
         dval_cnt <= dval_cnt + 1;
         dval_cyc <= cyc;
         if (hs_cyc >= 0 && (cyc - hs_cyc) < min_gap) min_gap <= cyc - hs_cyc;
      end
      if (fpu_dval_o && prev_dval) dval_double <= dval_double + 1;
      prev_dval <= fpu_dval_o;
      if (fpu_kill_o) begin kill_cnt <= kill_cnt + 1; kill_cyc <= cyc; end
      if (fpu_valid_i) fval_cyc <= cyc;
      if (resp_valid_o && resp_ready_i) begin hs_cnt <= hs_cnt + 1; hs_cyc <= cyc; end
      if (int'(fifo_count_o) > max_cnt) max_cnt <= int'(fifo_count_o);
      if (!rst_i && prev_stall &&
          !(resp_valid_o && resp_data_o == p_data && resp_flags_o == p_flags &&
            resp_tag_o == p_tag && resp_err_o == p_err))
         stab_bad <= stab_bad + 1;
      prev_stall <= !rst_i && resp_valid_o && !resp_ready_i;
      p_data <= resp_data_o; p_flags <= resp_flags_o; p_tag <= resp_tag_o; p_err <= resp_err_o;
      cyc <= cyc + 1;
   end

   // ---------------- Reference model ----------------
   typedef struct {
      logic [31:0]      d;
      logic [2:0]       f;
      logic [1:0]       e;
      logic [TAG_W-1:0] t;
   } exp_t;
   exp_t exp_q[$];

   function automatic exp_t ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                      input logic [TAG_W-1:0] t, input bit hng);
      exp_t e;
      e.t = t; e.d = '0; e.f = '0; e.e = 2'b00;
      if (c < 4'd1 || c > 4'd5)  e.e = 2'b01;
      else if (hng)              e.e = 2'b10;
      else if (c == 4'd4)        e.f = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
      else                       e.d = fpu_fn(c, a, b);
      return e;
   endfunction

   int acc_cyc  = 0;
   int resp_cyc = 0;

   task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
      int n = 0;
      req_valid_i = 1'b1; req_cmd_i = c; req_a_i = a; req_b_i = b; req_tag_i = t;
      while (!req_ready_o && n < 2000) begin @(posedge clk_i); #1; n++; end
      chk("push_accepted", req_ready_o, 1'b1);
      if (req_ready_o) begin
         @(posedge clk_i); #1;
         acc_cyc = cyc;
         exp_q.push_back(ref_model(c, a, b, t, hang));
      end
      req_valid_i = 1'b0;
   endtask

   task automatic pop_resp(input string nm);
      exp_t e;
      int   n = 0;
      resp_ready_i = 1'b1;
      while (!resp_valid_o && n < 1000) begin @(posedge clk_i); #1; n++; end
      chk({nm, "_resp_seen"}, resp_valid_o, 1'b1);
      chk({nm, "_exp_avail"}, (exp_q.size() != 0), 1'b1);
      if (resp_valid_o && exp_q.size() != 0) begin
         resp_cyc = cyc;
         e = exp_q.pop_front();
         chk({nm, "_data"},  resp_data_o,  e.d);
         chk({nm, "_flags"}, resp_flags_o, e.f);
         chk({nm, "_err"},   resp_err_o,   e.e);
         chk({nm, "_tag"},   resp_tag_o,   e.t);
         @(posedge clk_i); #1;
      end
      resp_ready_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, k0, h0, k;
      logic [3:0] c;
      rst_i = 1'b1; req_valid_i = 1'b0; req_cmd_i = '0; req_a_i = '0; req_b_i = '0;
      req_tag_i = '0; resp_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_resp_valid", resp_valid_o, 1'b0);
      chk("rst_fifo_count", fifo_count_o, 0);
      chk("rst_busy",       busy_o,       1'b0);
      chk("rst_dval",       fpu_dval_o,   1'b0);
      chk("rst_kill",       fpu_kill_o,   1'b0);
      chk("rst_fpu_cmd",    fpu_cmd_o,    4'h0);
      chk("rst_resp_data",  resp_data_o,  32'h0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_req_ready", req_ready_o, 1'b1);

      // Add 1.0 + 2.0, 17-cycle FPU latency
      lat_as = 17;
      d0 = dval_cnt;
      push(4'h1, 32'h3F80_0000, 32'h4000_0000, 4'd3);
      pop_resp("add");
      chk("add_dval_pulses", dval_cnt - d0, 1);
      chk("add_issue_lat",   dval_cyc - acc_cyc, 1);
      chk("add_resp_lat",    resp_cyc - fval_cyc, 2);
      chk("add_fval_lat",    fval_cyc - dval_cyc, 17);

      // Compare 5.0 vs 3.0
      lat_as = 3;
      push(4'h4, 32'h40A0_0000, 32'h4040_0000, 4'd5);
      pop_resp("cmp");

      // Unsupported opcode then a multiply
      d0 = dval_cnt;
      push(4'h7, $urandom, $urandom, 4'd9);
      pop_resp("unsup");
      chk("unsup_resp_lat",  resp_cyc - acc_cyc, 1);
      chk("unsup_no_dval",   dval_cnt - d0, 0);
      chk("unsup_not_sent",  fpu_cmd_o, 4'h4);
      push(4'h3, $urandom, $urandom, 4'd10);
      pop_resp("mul_after_unsup");
      chk("mul_dval_pulses", dval_cnt - d0, 1);

      // Fill FIFO with the response port stalled
      lat_as = 3; lat_mul = 4; lat_div = 6;
      for (int i = 0; i < 5; i++)
         push(4'($urandom_range(1, 5)), $urandom, $urandom, TAG_W'(i));
      chk("fill_req_ready", req_ready_o, 1'b0);
      chk("fill_count",     fifo_count_o, 4);
      req_valid_i = 1'b1; req_cmd_i = 4'h1; req_tag_i = 4'd15;
      repeat (5) @(posedge clk_i);
      #1;
      chk("sixth_blocked_count", fifo_count_o, 4);
      chk("sixth_blocked_ready", req_ready_o, 1'b0);
      req_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) pop_resp("fill_drain");
      chk("fill_max_count", max_cnt, DEPTH);

      // Divide that never completes
      hang = 1'b1;
      k0 = kill_cnt;
      push(4'h5, 32'h4120_0000, 32'h0000_0000, 4'd11);
      pop_resp("div_timeout");
      hang = 1'b0;
      chk("to_kill_pulses", kill_cnt - k0, 1);
      chk("to_kill_time",   kill_cyc - dval_cyc, TIMEOUT + 1);
      chk("to_resp_time",   resp_cyc - kill_cyc, 1);
      lat_as = 5;
      push(4'h1, $urandom, $urandom, 4'd12);
      pop_resp("after_kill");
      chk("after_kill_issue", (dval_cyc > kill_cyc), 1'b1);

      // Reset while a divide is in WAIT_VAL with two queued behind it
      lat_div = 100;
      for (int i = 1; i <= 3; i++) push(4'h5, $urandom, $urandom, TAG_W'(i));
      repeat (5) @(posedge clk_i);
      #1;
      chk("prerst_count", fifo_count_o, 2);
      h0 = hs_cnt;
      rst_i = 1'b1;
      #1;
      chk("midrst_count",      fifo_count_o, 0);
      chk("midrst_busy",       busy_o,       1'b0);
      chk("midrst_resp_valid", resp_valid_o, 1'b0);
      chk("midrst_dval",       fpu_dval_o,   1'b0);
      chk("midrst_kill",       fpu_kill_o,   1'b0);
      chk("midrst_fpu_cmd",    fpu_cmd_o,    4'h0);
      chk("midrst_fpu_din1",   fpu_din1_o,   32'h0);
      chk("midrst_resp_tag",   resp_tag_o,   4'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      exp_q.delete();
      @(posedge clk_i); #1;
      chk("postrst_req_ready", req_ready_o, 1'b1);
      resp_ready_i = 1'b1;
      repeat (20) @(posedge clk_i);
      #1;
      chk("postrst_no_resp", hs_cnt - h0, 0);
      resp_ready_i = 1'b0;
      lat_as = 4;
      push(4'h1, 32'h3F80_0000, 32'h4000_0000, 4'd6);
      pop_resp("postrst_add");

      // Randomized bursts
      lat_as = $urandom_range(1, 12); lat_mul = $urandom_range(1, 12); lat_div = $urandom_range(1, 12);
      for (int r = 0; r < 12; r++) begin
         k = $urandom_range(1, 4);
         for (int i = 0; i < k; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
            push(c, $urandom, (i == 0) ? 32'h4040_0000 : $urandom, TAG_W'($urandom));
         end
         for (int i = 0; i < k; i++) pop_resp("rand");
      end

      chk("final_exp_empty",   exp_q.size(), 0);
      chk("final_dval_single", dval_double, 0);
      chk("final_resp_stable", stab_bad, 0);
      chk("final_b2b_gap",     min_gap, 2);
      chk("final_max_count",   (max_cnt <= DEPTH), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
